// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO expander banks: register map and APB FSM encoding.
package gpio_pkg;

  localparam int unsigned GPIO_DATA_WIDTH = 8;

  localparam logic [2:0] REG_DIR      = 3'd0;
  localparam logic [2:0] REG_OUT      = 3'd1;
  localparam logic [2:0] REG_IN       = 3'd2;
  localparam logic [2:0] REG_IRQ_EN   = 3'd3;
  localparam logic [2:0] REG_EDGE     = 3'd4;
  localparam logic [2:0] REG_IRQ_STAT = 3'd5;
  localparam logic [2:0] REG_ID       = 3'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/gpio_edge_sync.sv
// Pad input synchronizer with previous-value flop and per-bit polarity edge detect.
module gpio_edge_sync
  import gpio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = GPIO_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_gpio,
  input  logic [DATA_WIDTH-1:0] i_edge_pol,
  input  logic                  i_mask,
  output logic [DATA_WIDTH-1:0] o_in_sync,
  output logic [DATA_WIDTH-1:0] o_edge_pulse
);

  logic [DATA_WIDTH-1:0] r_sync1;
  logic [DATA_WIDTH-1:0] r_sync2;
  logic [DATA_WIDTH-1:0] r_prev;
  logic [DATA_WIDTH-1:0] w_rise;
  logic [DATA_WIDTH-1:0] w_fall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= i_gpio;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_comb begin
    w_rise       = r_sync2 & ~r_prev;
    w_fall       = ~r_sync2 & r_prev;
    o_edge_pulse = '0;
    if (!i_mask) begin
      o_edge_pulse = (w_rise & i_edge_pol) | (w_fall & ~i_edge_pol);
    end
  end

  assign o_in_sync = r_sync2;

endmodule

// File: rtl/apb_gpio_bank.sv
// APB responder for one 8-bit GPIO bank: direction/output/input registers,
// edge-detect interrupt status, configurable wait states and unmapped-address error.
module apb_gpio_bank
  import gpio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = GPIO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] BANK_ID = DATA_WIDTH'(8'hA0)
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic [DATA_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam logic [ADDR_WIDTH-1:0] A_DIR  = ADDR_WIDTH'(REG_DIR);
  localparam logic [ADDR_WIDTH-1:0] A_OUT  = ADDR_WIDTH'(REG_OUT);
  localparam logic [ADDR_WIDTH-1:0] A_IN   = ADDR_WIDTH'(REG_IN);
  localparam logic [ADDR_WIDTH-1:0] A_EN   = ADDR_WIDTH'(REG_IRQ_EN);
  localparam logic [ADDR_WIDTH-1:0] A_EDGE = ADDR_WIDTH'(REG_EDGE);
  localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(REG_IRQ_STAT);
  localparam logic [ADDR_WIDTH-1:0] A_ID   = ADDR_WIDTH'(REG_ID);

  apb_state_e            r_state, w_state_d;
  logic [1:0]            r_cnt, w_cnt_d;
  logic                  r_pready, r_pslverr, r_irq, r_edge_mask;
  logic [DATA_WIDTH-1:0] r_prdata, r_dir, r_out, r_irq_en, r_edge, r_stat;
  logic [DATA_WIDTH-1:0] w_in_sync, w_edge_pulse, w_rdata, w_clr;
  logic                  w_ready_d, w_commit, w_wr, w_addr_ok;

  gpio_edge_sync #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_edge_sync (
    .i_clk       (pclk),
    .i_rst       (preset),
    .i_gpio      (gpio_in),
    .i_edge_pol  (r_edge),
    .i_mask      (r_edge_mask),
    .o_in_sync   (w_in_sync),
    .o_edge_pulse(w_edge_pulse)
  );

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      IDLE:   if (psel && !penable) w_state_d = SETUP;
      SETUP: begin
        if (psel) begin
          w_state_d = ACCESS;
          w_cnt_d   = 2'(WAIT_STATES);
        end else begin
          w_state_d = IDLE;
        end
      end
      ACCESS: begin
        if (r_cnt == 2'd0)          w_state_d = DONE;
        else if (!(psel && penable)) w_state_d = IDLE;
        else                         w_cnt_d   = r_cnt - 2'd1;
      end
      DONE:   w_state_d = (psel && !penable) ? SETUP : IDLE;
    endcase
  end

  // Outputs are registered, so the pready cycle is predicted from the next state/count.
  assign w_ready_d = (w_state_d == ACCESS) && (w_cnt_d == 2'd0);
  assign w_commit  = (r_state == ACCESS) && (r_cnt == 2'd0);
  assign w_wr      = w_commit && pwrite;
  assign w_addr_ok = (paddr <= A_ID);
  assign w_clr     = (w_wr && (paddr == A_STAT)) ? pwdata : '0;

  always_comb begin
    w_rdata = '0;
    if      (paddr == A_DIR)  w_rdata = r_dir;
    else if (paddr == A_OUT)  w_rdata = r_out;
    else if (paddr == A_IN)   w_rdata = w_in_sync;
    else if (paddr == A_EN)   w_rdata = r_irq_en;
    else if (paddr == A_EDGE) w_rdata = r_edge;
    else if (paddr == A_STAT) w_rdata = r_stat;
    else if (paddr == A_ID)   w_rdata = BANK_ID;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_pready    <= 1'b0;
      r_pslverr   <= 1'b0;
      r_prdata    <= '0;
      r_dir       <= '0;
      r_out       <= '0;
      r_irq_en    <= '0;
      r_edge      <= '0;
      r_stat      <= '0;
      r_irq       <= 1'b0;
      r_edge_mask <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_pready  <= w_ready_d;
      r_pslverr <= w_ready_d && !w_addr_ok;
      r_prdata  <= (w_ready_d && !pwrite) ? w_rdata : '0;
      if (w_wr) begin
        if (paddr == A_DIR)  r_dir    <= pwdata;
        if (paddr == A_OUT)  r_out    <= pwdata;
        if (paddr == A_EN)   r_irq_en <= pwdata;
        if (paddr == A_EDGE) r_edge   <= pwdata;
      end
      // Polarity change can look like an edge for one cycle; mask it.
      r_edge_mask <= w_wr && (paddr == A_EDGE);
      r_stat      <= (r_stat & ~w_clr) | w_edge_pulse;
      r_irq       <= |(r_stat & r_irq_en);
    end
  end

  assign pready   = r_pready;
  assign pslverr  = r_pslverr;
  assign prdata   = r_prdata;
  assign gpio_oe  = r_dir;
  assign gpio_out = r_out;
  assign irq      = r_irq;

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Directed bench for apb_gpio_bank: one instance with no wait states, one with two.
module tb_apb_gpio_bank;

  logic       pclk = 1'b0;
  logic       preset;
  logic       psel0, psel2, penable, pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata, gpio_in;
  logic [7:0] prdata0, prdata2, gpio_out0, gpio_out2, gpio_oe0, gpio_oe2;
  logic       pready0, pready2, pslverr0, pslverr2, irq0, irq2;

  int unsigned n_err = 0;
  int unsigned n_chk = 0;
  logic        gin_pending = 1'b0;
  logic [7:0]  gin_next = 8'h00;

  logic [7:0] rd;
  logic       err;
  int         lat;
  logic       seen;

  always #5 pclk = ~pclk;

  apb_gpio_bank #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .WAIT_STATES(0), .BANK_ID(8'hA0)
  ) u_dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
    .gpio_in(gpio_in), .gpio_out(gpio_out0), .gpio_oe(gpio_oe0), .irq(irq0)
  );

  apb_gpio_bank #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .WAIT_STATES(2), .BANK_ID(8'hB2)
  ) u_dut2 (
    .pclk(pclk), .preset(preset), .psel(psel2), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata2), .pready(pready2), .pslverr(pslverr2),
    .gpio_in(gpio_in), .gpio_out(gpio_out2), .gpio_oe(gpio_oe2), .irq(irq2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apb(input bit sel2, input bit wr, input logic [2:0] addr,
                     input logic [7:0] wd, output logic [7:0] o_rd,
                     output logic o_err, output int o_lat);
    bit got;
    @(posedge pclk); #1;
    psel0 = !sel2; psel2 = sel2; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wd;
    if (gin_pending) begin
      gpio_in = gin_next;
      gin_pending = 1'b0;
    end
    @(posedge pclk); #1;
    penable = 1'b1;
    o_lat = 0; o_rd = '0; o_err = 1'b0; got = 1'b0;
    while (o_lat < 10) begin
      @(posedge pclk); #1;
      o_lat++;
      if (sel2 ? pready2 : pready0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("pready_timeout", 0, 1);
    o_rd  = sel2 ? prdata2 : prdata0;
    o_err = sel2 ? pslverr2 : pslverr0;
    @(posedge pclk); #1;
    chk("pready_one_cycle", sel2 ? pready2 : pready0, 0);
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    preset = 1'b1; psel0 = 0; psel2 = 0; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0; gpio_in = 8'h00;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_pready", pready0, 0);
    chk("rst_oe", gpio_oe0, 8'h00);
    chk("rst_out", gpio_out0, 8'h00);
    chk("rst_irq", irq0, 0);
    preset = 1'b0;

    // Write / read-back and latency
    apb(0, 1, 3'd0, 8'hF0, rd, err, lat);
    chk("dir_lat_ws0", lat, 1);
    chk("dir_oe_pad", gpio_oe0, 8'hF0);
    apb(0, 1, 3'd1, 8'h5A, rd, err, lat);
    chk("out_pad", gpio_out0, 8'h5A);
    apb(0, 0, 3'd0, 8'h00, rd, err, lat);
    chk("dir_read", rd, 8'hF0);
    chk("dir_read_err", err, 0);
    apb(1, 1, 3'd0, 8'h33, rd, err, lat);
    chk("dir_lat_ws2", lat, 3);
    chk("dir_oe_pad_ws2", gpio_oe2, 8'h33);
    apb(1, 0, 3'd0, 8'h00, rd, err, lat);
    chk("dir_read_ws2", rd, 8'h33);
    chk("rd_lat_ws2", lat, 3);

    // Input sampling and ID
    gpio_in = 8'h3C;
    repeat (3) @(posedge pclk);
    apb(0, 0, 3'd2, 8'h00, rd, err, lat);
    chk("in_read", rd, 8'h3C);
    apb(0, 0, 3'd6, 8'h00, rd, err, lat);
    chk("id_read", rd, 8'hA0);
    apb(0, 1, 3'd6, 8'hFF, rd, err, lat);
    chk("id_write_err", err, 0);
    apb(0, 0, 3'd6, 8'h00, rd, err, lat);
    chk("id_after_write", rd, 8'hA0);
    apb(1, 0, 3'd6, 8'h00, rd, err, lat);
    chk("id_read_ws2", rd, 8'hB2);

    // Rising-edge interrupt and W1C
    apb(0, 1, 3'd4, 8'h01, rd, err, lat);
    apb(0, 1, 3'd3, 8'h01, rd, err, lat);
    chk("irq_before_edge", irq0, 0);
    gpio_in = 8'h3D;
    repeat (5) @(posedge pclk);
    #1;
    chk("irq_rise", irq0, 1);
    apb(0, 0, 3'd5, 8'h00, rd, err, lat);
    chk("stat_rise", rd, 8'h01);
    apb(0, 1, 3'd5, 8'h01, rd, err, lat);
    @(posedge pclk); #1;
    chk("irq_cleared", irq0, 0);
    apb(0, 0, 3'd5, 8'h00, rd, err, lat);
    chk("stat_cleared", rd, 8'h00);

    // Falling input is ignored with rising polarity; then W1C races a new edge
    gpio_in = 8'h3C;
    repeat (5) @(posedge pclk);
    #1;
    chk("irq_fall_ignored", irq0, 0);
    gpio_in = 8'h3D;
    repeat (5) @(posedge pclk);
    #1;
    chk("irq_rise2", irq0, 1);
    gpio_in = 8'h3C;
    repeat (5) @(posedge pclk);
    gin_next = 8'h3D;
    gin_pending = 1'b1;
    apb(0, 1, 3'd5, 8'h01, rd, err, lat);
    @(posedge pclk); #1;
    chk("irq_set_wins", irq0, 1);
    apb(0, 0, 3'd5, 8'h00, rd, err, lat);
    chk("stat_set_wins", rd, 8'h01);

    // Unmapped address
    apb(0, 0, 3'd7, 8'h00, rd, err, lat);
    chk("unmapped_rd_err", err, 1);
    chk("unmapped_rd_data", rd, 8'h00);
    apb(0, 1, 3'd7, 8'hFF, rd, err, lat);
    chk("unmapped_wr_err", err, 1);
    apb(0, 0, 3'd0, 8'h00, rd, err, lat);
    chk("dir_after_unmapped", rd, 8'hF0);

    // Abort during a wait state
    @(posedge pclk); #1;
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'hAA;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel2 = 1'b0; penable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge pclk); #1;
      if (pready2) seen = 1'b1;
    end
    chk("abort_no_pready", seen, 0);
    chk("abort_oe", gpio_oe2, 8'h33);
    apb(1, 0, 3'd0, 8'h00, rd, err, lat);
    chk("abort_dir", rd, 8'h33);

    // Reset in the middle of a wait-state transfer
    @(posedge pclk); #1;
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'h55;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b1;
    #1;
    chk("mid_rst_pready", pready2, 0);
    chk("mid_rst_oe2", gpio_oe2, 8'h00);
    chk("mid_rst_oe0", gpio_oe0, 8'h00);
    chk("mid_rst_out0", gpio_out0, 8'h00);
    chk("mid_rst_irq0", irq0, 0);
    psel2 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    apb(0, 0, 3'd0, 8'h00, rd, err, lat);
    chk("post_rst_dir0", rd, 8'h00);
    apb(1, 0, 3'd0, 8'h00, rd, err, lat);
    chk("post_rst_dir2", rd, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
